// File: rtl/xbar_out_slice.sv
// Crossbar per-master output slice: grant-locked source mux feeding a 2-entry skid buffer, 1-cycle latency.
// Backpressure: s_ready_o drops once the skid entry fills; defining XBAR_OUT_PKT_CNT_EN adds pkt_cnt_o.
module xbar_out_slice #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 3,
    parameter int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [S_DATA_COUNT-1:0]              grant_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic [T_ID___WIDTH-1:0]              m_id_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
`ifdef XBAR_OUT_PKT_CNT_EN
    output logic [CNT_WIDTH-1:0]                 pkt_cnt_o,
`endif
    output logic                                 busy_o
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                  state_q;
    logic [T_ID___WIDTH-1:0] sel_q;

    logic                    main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic [T_DATA_WIDTH-1:0] main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;
    logic                    main_last_q, main_last_d, skid_last_q, skid_last_d;
    logic [T_ID___WIDTH-1:0] main_id_q, main_id_d, skid_id_q, skid_id_d;

    logic                    src_vld;
    logic [T_ID___WIDTH-1:0] src_idx;
    logic                    in_rdy, in_vld, in_last, accept, consume;
    logic [T_DATA_WIDTH-1:0] in_dat;

    // Once locked the arbiter's grant is ignored until the packet's last beat.
    always_comb begin
        src_vld = 1'b0;
        src_idx = '0;
        if (state_q == LOCKED) begin
            src_vld = 1'b1;
            src_idx = sel_q;
        end else begin
            for (int k = S_DATA_COUNT - 1; k >= 0; k--) begin
                if (grant_i[k]) begin
                    src_vld = 1'b1;
                    src_idx = T_ID___WIDTH'(k);
                end
            end
        end
    end

    assign in_rdy = !skid_vld_q && !rst;

    always_comb begin
        s_ready_o = '0;
        in_vld    = 1'b0;
        in_last   = 1'b0;
        in_dat    = '0;
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            if (src_vld && (src_idx == T_ID___WIDTH'(k))) begin
                s_ready_o[k] = in_rdy;
                in_vld       = s_valid_i[k];
                in_last      = s_last_i[k];
                in_dat       = s_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
            end
        end
    end

    assign accept  = in_vld && in_rdy;
    assign consume = main_vld_q && m_ready_i;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_dat_d  = main_dat_q;
        main_last_d = main_last_q;
        main_id_d   = main_id_q;
        skid_vld_d  = skid_vld_q;
        skid_dat_d  = skid_dat_q;
        skid_last_d = skid_last_q;
        skid_id_d   = skid_id_q;
        if (consume) begin
            if (skid_vld_q) begin
                main_dat_d  = skid_dat_q;
                main_last_d = skid_last_q;
                main_id_d   = skid_id_q;
                skid_vld_d  = 1'b0;
            end else begin
                main_vld_d  = 1'b0;
            end
        end
        // accept never coincides with consume while skid is full, since in_rdy is low then
        if (accept) begin
            if (!main_vld_q || consume) begin
                main_vld_d  = 1'b1;
                main_dat_d  = in_dat;
                main_last_d = in_last;
                main_id_d   = src_idx;
            end else begin
                skid_vld_d  = 1'b1;
                skid_dat_d  = in_dat;
                skid_last_d = in_last;
                skid_id_d   = src_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            main_vld_q  <= 1'b0;
            main_dat_q  <= '0;
            main_last_q <= 1'b0;
            main_id_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_dat_q  <= '0;
            skid_last_q <= 1'b0;
            skid_id_q   <= '0;
        end else begin
            if (accept) begin
                if (in_last) begin
                    state_q <= IDLE;
                end else begin
                    state_q <= LOCKED;
                    sel_q   <= src_idx;
                end
            end
            main_vld_q  <= main_vld_d;
            main_dat_q  <= main_dat_d;
            main_last_q <= main_last_d;
            main_id_q   <= main_id_d;
            skid_vld_q  <= skid_vld_d;
            skid_dat_q  <= skid_dat_d;
            skid_last_q <= skid_last_d;
            skid_id_q   <= skid_id_d;
        end
    end

    assign m_valid_o = main_vld_q;
    assign m_data_o  = main_dat_q;
    assign m_last_o  = main_last_q;
    assign m_id_o    = main_id_q;
    assign busy_o    = (state_q == LOCKED);

`ifdef XBAR_OUT_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] pkt_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else if (consume && main_last_q) begin
            pkt_cnt_q <= pkt_cnt_q + 1'b1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`else
    // packet counter not built
`endif

endmodule
